spdif_rx_scheduler: RTL and testbench

SPDIF_RX_SCHEDULER -- requirements
Module: spdif_rx_scheduler

---
 rtl/spdif_pkg.sv | 24 ++
 rtl/spdif_ui_meter.sv | 44 ++++
 rtl/spdif_rx_scheduler.sv | 159 +++++++++++++++
 tb/tb_spdif_rx_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF receive scheduler.
package spdif_pkg;

    typedef enum logic [2:0] {
        StSettle  = 3'd0,
        StMeasure = 3'd1,
        StVerify  = 3'd2,
        StLocked  = 3'd3,
        StFail    = 3'd4
    } state_e;

    localparam int unsigned CNT_W = 16;

    localparam logic [7:0] T1_DEFAULT = 8'd20;
    localparam logic [7:0] T2_DEFAULT = 8'd38;
    localparam logic [7:0] T3_DEFAULT = 8'd42;
    localparam logic [7:0] UI_MIN_LO  = 8'd6;
    localparam logic [7:0] UI_MIN_HI  = 8'd60;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spdif_ui_meter.sv
// Minimum edge-length tracker and decoder threshold registers.
module spdif_ui_meter
    import spdif_pkg::*;
(
    input  logic       clk,
    input  logic       resetb,
    input  logic       i_clear,
    input  logic       i_sample,
    input  logic [7:0] i_len,
    input  logic       i_load,
    output logic       o_in_range,
    output logic [7:0] o_t1,
    output logic [7:0] o_t2,
    output logic [7:0] o_t3
);
    logic [7:0] r_ui_min;
    logic [7:0] w_ui_nxt;
    logic [7:0] r_t1, r_t2, r_t3;

    // Include the current strobe so the closing edge of the window is measured too.
    assign w_ui_nxt   = (i_sample && (i_len < r_ui_min)) ? i_len : r_ui_min;
    assign o_in_range = (w_ui_nxt >= UI_MIN_LO) && (w_ui_nxt <= UI_MIN_HI);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_ui_min <= 8'hFF;
            r_t1     <= T1_DEFAULT;
            r_t2     <= T2_DEFAULT;
            r_t3     <= T3_DEFAULT;
        end else begin
            r_ui_min <= i_clear ? 8'hFF : w_ui_nxt;
            if (i_load) begin
                r_t1 <= w_ui_nxt + (w_ui_nxt >> 1);
                r_t2 <= (w_ui_nxt << 1) + (w_ui_nxt >> 1);
                r_t3 <= (w_ui_nxt << 1) + w_ui_nxt - (w_ui_nxt >> 2);
            end
        end
    end

    assign o_t1 = r_t1;
    assign o_t2 = r_t2;
    assign o_t3 = r_t3;

endmodule

// File: rtl/spdif_rx_scheduler.sv
// Input scan / lock FSM steering an external S/PDIF decoder.
// Define SPDIF_AUTO_SCAN_EN to rotate inputs on failure; otherwise failures retry input 0.
module spdif_rx_scheduler
    import spdif_pkg::*;
#(
    parameter int unsigned NUM_IN        = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MEAS_EDGES    = 256,
    parameter int unsigned VERIFY_EDGES  = 1024,
    parameter int unsigned SYNC_REQ      = 3,
    parameter int unsigned WDOG_CYCLES   = 8192
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [NUM_IN-1:0] rx_in,
    input  logic              edge_valid,
    input  logic [7:0]        edge_len,
    input  logic              sync_seen,
    input  logic              force_en,
    input  logic [1:0]        force_sel,
    output logic [1:0]        rx_sel,
    output logic              rx_mux,
    output logic              dec_resetb,
    output logic [7:0]        t1,
    output logic [7:0]        t2,
    output logic [7:0]        t3,
    output logic              audio_locked
);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_EDGES - 1);
    localparam logic [CNT_W-1:0] VERIFY_LAST = CNT_W'(VERIFY_EDGES - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_REQ - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(WDOG_CYCLES - 1);

    state_e           r_state, w_state_nxt;
    logic [1:0]       r_rx_sel, w_rx_sel_nxt;
    logic [CNT_W-1:0] r_settle_cnt, w_settle_nxt;
    logic [CNT_W-1:0] r_edge_cnt, w_edge_nxt;
    logic [CNT_W-1:0] r_sync_cnt, w_sync_nxt;
    logic [CNT_W-1:0] r_wdog_cnt, w_wdog_nxt;
    logic             r_locked;
    logic             w_edge_ok, w_force_hit, w_ui_ok;
    logic             w_meas_clear, w_meas_load, w_meas_sample, w_rx_mux;

    assign w_edge_ok     = edge_valid && (edge_len != 8'd0);
    assign w_force_hit   = force_en && (32'(force_sel) < NUM_IN) && (force_sel != r_rx_sel);
    assign w_meas_sample = (r_state == StMeasure) && w_edge_ok;

    always_comb begin
        w_state_nxt  = r_state;
        w_rx_sel_nxt = r_rx_sel;
        w_settle_nxt = r_settle_cnt;
        w_edge_nxt   = r_edge_cnt;
        w_sync_nxt   = r_sync_cnt;
        w_wdog_nxt   = r_wdog_cnt;
        case (r_state)
            StSettle: begin
                w_settle_nxt = sat_inc(r_settle_cnt);
                if (r_settle_cnt >= SETTLE_LAST) w_state_nxt = StMeasure;
            end
            StMeasure: begin
                w_wdog_nxt = edge_valid ? '0 : sat_inc(r_wdog_cnt);
                if (w_edge_ok) w_edge_nxt = sat_inc(r_edge_cnt);
                if (w_edge_ok && (r_edge_cnt >= MEAS_LAST)) begin
                    w_state_nxt = w_ui_ok ? StVerify : StFail;
                end else if (!edge_valid && (r_wdog_cnt >= WDOG_LAST)) begin
                    w_state_nxt = StFail;
                end
            end
            StVerify: begin
                w_wdog_nxt = edge_valid ? '0 : sat_inc(r_wdog_cnt);
                if (edge_valid) w_edge_nxt = sat_inc(r_edge_cnt);
                if (sync_seen) w_sync_nxt = sat_inc(r_sync_cnt);
                // A lock reached on the window's closing edge still counts as a lock.
                if (sync_seen && (r_sync_cnt >= SYNC_LAST)) begin
                    w_state_nxt = StLocked;
                end else if (edge_valid && (r_edge_cnt >= VERIFY_LAST)) begin
                    w_state_nxt = StFail;
                end else if (!edge_valid && (r_wdog_cnt >= WDOG_LAST)) begin
                    w_state_nxt = StFail;
                end
            end
            StLocked: begin
                w_wdog_nxt = sync_seen ? '0 : sat_inc(r_wdog_cnt);
                if (!sync_seen && (r_wdog_cnt >= WDOG_LAST)) w_state_nxt = StFail;
            end
            StFail: begin
                w_state_nxt = StSettle;
`ifdef SPDIF_AUTO_SCAN_EN
                if (!force_en) begin
                    w_rx_sel_nxt = (32'(r_rx_sel) + 32'd1 >= NUM_IN) ? 2'd0 : r_rx_sel + 2'd1;
                end
`else
                if (!force_en) w_rx_sel_nxt = 2'd0;
`endif
            end
            default: w_state_nxt = StSettle;
        endcase
        if (w_force_hit) begin
            w_state_nxt  = StSettle;
            w_rx_sel_nxt = force_sel;
        end
        if (w_force_hit || (w_state_nxt != r_state)) begin
            w_settle_nxt = '0;
            w_edge_nxt   = '0;
            w_sync_nxt   = '0;
            w_wdog_nxt   = '0;
        end
        w_meas_clear = (r_state == StSettle) && (w_state_nxt == StMeasure);
        w_meas_load  = (r_state == StMeasure) && (w_state_nxt == StVerify);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state      <= StSettle;
            r_rx_sel     <= 2'd0;
            r_settle_cnt <= '0;
            r_edge_cnt   <= '0;
            r_sync_cnt   <= '0;
            r_wdog_cnt   <= '0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_sel     <= w_rx_sel_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_edge_cnt   <= w_edge_nxt;
            r_sync_cnt   <= w_sync_nxt;
            r_wdog_cnt   <= w_wdog_nxt;
            // Lags state by one cycle, except an override drops it immediately.
            r_locked     <= (r_state == StLocked) && !w_force_hit;
        end
    end

    always_comb begin
        w_rx_mux = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(r_rx_sel) == i) w_rx_mux = rx_in[i];
        end
    end

    spdif_ui_meter u_meter (
        .clk        (clk),
        .resetb     (resetb),
        .i_clear    (w_meas_clear),
        .i_sample   (w_meas_sample),
        .i_len      (edge_len),
        .i_load     (w_meas_load),
        .o_in_range (w_ui_ok),
        .o_t1       (t1),
        .o_t2       (t2),
        .o_t3       (t3)
    );

    assign rx_sel       = r_rx_sel;
    assign rx_mux       = w_rx_mux;
    assign dec_resetb   = (r_state != StSettle);
    assign audio_locked = r_locked;

endmodule

// File: tb/tb_spdif_rx_scheduler.sv
// Scoreboard bench: stimulus queues expected lock/settle events, a negedge monitor checks them.
module tb_spdif_rx_scheduler;

    localparam int EV_LOCK   = 0;
    localparam int EV_UNLOCK = 1;
    localparam int EV_SETTLE = 2;
    localparam int EV_RUN    = 3;

    typedef struct {
        int kind;
        int sel;
        int t1;
        int t2;
        int t3;
        int gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetb;
    logic [2:0] rx_in;
    logic       edge_valid;
    logic [7:0] edge_len;
    logic       sync_seen;
    logic       force_en;
    logic [1:0] force_sel;
    logic [1:0] rx_sel;
    logic       rx_mux;
    logic       dec_resetb;
    logic [7:0] t1, t2, t3;
    logic       audio_locked;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   last_sync = 0;
    bit   prev_l = 1'b0, prev_d = 1'b0, cur_l, cur_d;
    int   lowcnt = 0;
    int   scan_sel;

    spdif_rx_scheduler #(
        .NUM_IN (3)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .rx_in        (rx_in),
        .edge_valid   (edge_valid),
        .edge_len     (edge_len),
        .sync_seen    (sync_seen),
        .force_en     (force_en),
        .force_sel    (force_sel),
        .rx_sel       (rx_sel),
        .rx_mux       (rx_mux),
        .dec_resetb   (dec_resetb),
        .t1           (t1),
        .t2           (t2),
        .t3           (t3),
        .audio_locked (audio_locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int sel, input int a, input int b, input int c,
                        input int gap);
        exp_t e;
        e.kind = kind; e.sel = sel; e.t1 = a; e.t2 = b; e.t3 = c; e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic handle(input int kind, input int meas);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, want none", kind, cyc);
            return;
        end
        e = sb_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_sel", 32'(rx_sel), e.sel);
        if (e.kind == EV_LOCK) begin
            chk("lock_t1", 32'(t1), e.t1);
            chk("lock_t2", 32'(t2), e.t2);
            chk("lock_t3", 32'(t3), e.t3);
        end
        if (e.gap != 0) chk("event_gap", meas, e.gap);
    endtask

    // Monitor: derive events from output transitions, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cur_l = (audio_locked === 1'b1);
            cur_d = (dec_resetb === 1'b1);
            if (!cur_d) lowcnt = prev_d ? 1 : lowcnt + 1;
            if (cur_l && !prev_l) handle(EV_LOCK, cyc - last_sync);
            if (!cur_l && prev_l) handle(EV_UNLOCK, cyc - last_sync);
            if (!cur_d && prev_d) handle(EV_SETTLE, 0);
            if (cur_d && !prev_d) handle(EV_RUN, lowcnt);
            prev_l = cur_l;
            prev_d = cur_d;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({"pending_", name}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // n counted edges of length len0*(1,2,3); optional zero-length strobes interleaved.
    task automatic send(input int n, input int len0, input int sync_every, input bit zeros);
        for (int i = 0; i < n; i++) begin
            if (zeros && (i % 50) == 7) begin
                edge_valid = 1'b1; edge_len = 8'd0; sync_seen = 1'b0;
                step();
            end
            edge_valid = 1'b1;
            edge_len   = 8'(len0 * (1 + (i % 3)));
            sync_seen  = (sync_every != 0) && ((i % sync_every) == sync_every - 1);
            if (sync_seen) last_sync = cyc + 1;
            step();
        end
        edge_valid = 1'b0;
        edge_len   = 8'd0;
        sync_seen  = 1'b0;
    endtask

    initial begin
        resetb = 1'b0; rx_in = 3'b000; edge_valid = 1'b0; edge_len = 8'd0;
        sync_seen = 1'b0; force_en = 1'b0; force_sel = 2'd0;
        push(EV_RUN, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("rst_rx_sel", 32'(rx_sel), 0);
        chk("rst_dec_resetb", 32'(dec_resetb), 0);
        chk("rst_locked", 32'(audio_locked), 0);
        chk("rst_t1", 32'(t1), 20);
        chk("rst_t2", 32'(t2), 38);
        chk("rst_t3", 32'(t3), 42);
        resetb = 1'b1;
        wait_empty(50, "reset_release");

        // ui=14 on input 0, lock after 3 syncs.
        push(EV_LOCK, 0, 21, 35, 39, 1);
        send(256, 14, 0, 1'b1);
        send(9, 14, 3, 1'b0);
        wait_empty(100, "lock_ui14");

        // Stream stops: unlock 8193 cycles after the last sync, then rescan.
`ifdef SPDIF_AUTO_SCAN_EN
        scan_sel = 1;
`else
        scan_sel = 0;
`endif
        push(EV_UNLOCK, scan_sel, 0, 0, 0, 8193);
        push(EV_SETTLE, scan_sel, 0, 0, 0, 0);
        push(EV_RUN, scan_sel, 0, 0, 0, 4);
        send(20, 14, 4, 1'b0);
        wait_empty(8300, "locked_wdog");

`ifdef SPDIF_AUTO_SCAN_EN
        push(EV_LOCK, 1, 15, 25, 28, 1);
        send(256, 10, 0, 1'b1);
        send(9, 10, 3, 1'b0);
        wait_empty(100, "lock_in1");
        push(EV_UNLOCK, 0, 0, 0, 0, 0);
        push(EV_SETTLE, 0, 0, 0, 0, 0);
        push(EV_RUN, 0, 0, 0, 0, 4);
        force_en = 1'b1; force_sel = 2'd0;
        step();
        force_en = 1'b0;
        wait_empty(50, "force_back0");
`else
        // Silent input 0 keeps failing and retrying input 0.
        repeat (2) begin
            push(EV_SETTLE, 0, 0, 0, 0, 0);
            push(EV_RUN, 0, 0, 0, 0, 4);
        end
        wait_empty(2 * 8200 + 100, "silent_retry");
        chk("retry_rx_sel", 32'(rx_sel), 0);
`endif

        // Lock on input 0 at ui=20, then exercise the override.
        push(EV_LOCK, 0, 30, 50, 55, 1);
        send(256, 20, 0, 1'b1);
        send(9, 20, 3, 1'b0);
        wait_empty(100, "lock_ui20");
        force_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            force_sel = (i % 2 == 0) ? 2'd3 : 2'd0;
            step();
        end
        chk("force_ignored_sel", 32'(rx_sel), 0);
        chk("force_ignored_lock", 32'(audio_locked), 1);
        push(EV_UNLOCK, 2, 0, 0, 0, 0);
        push(EV_SETTLE, 2, 0, 0, 0, 0);
        push(EV_RUN, 2, 0, 0, 0, 4);
        force_sel = 2'd2;
        step();
        chk("force_rx_sel", 32'(rx_sel), 2);
        chk("force_dec_resetb", 32'(dec_resetb), 0);
        chk("force_locked", 32'(audio_locked), 0);
        force_en = 1'b0;
        rx_in = 3'b100;
        #1 chk("mux_sel2_hi", 32'(rx_mux), 1);
        rx_in = 3'b011;
        #1 chk("mux_sel2_lo", 32'(rx_mux), 0);
        wait_empty(50, "force_sel2");

        // ui=4 is out of range: fail after 256 edges, thresholds untouched, wrap to input 0.
        push(EV_SETTLE, 0, 0, 0, 0, 0);
        push(EV_RUN, 0, 0, 0, 0, 4);
        send(256, 4, 0, 1'b1);
        wait_empty(100, "ui4_fail");
        chk("ui4_t1", 32'(t1), 30);
        chk("ui4_t2", 32'(t2), 50);
        chk("ui4_t3", 32'(t3), 55);
        rx_in = 3'b001;
        #1 chk("mux_sel0", 32'(rx_mux), 1);

        // Reset mid-measurement aborts to reset values.
        send(20, 14, 0, 1'b0);
        push(EV_SETTLE, 0, 0, 0, 0, 0);
        push(EV_RUN, 0, 0, 0, 0, 0);
        resetb = 1'b0;
        step();
        chk("midrst_rx_sel", 32'(rx_sel), 0);
        chk("midrst_dec_resetb", 32'(dec_resetb), 0);
        chk("midrst_t1", 32'(t1), 20);
        chk("midrst_t2", 32'(t2), 38);
        chk("midrst_t3", 32'(t3), 42);
        step();
        resetb = 1'b1;
        wait_empty(50, "midrst_release");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
